// File: rtl/simple_risc_writeback.sv
// SimpleRISC writeback stage: latches the memory-stage bundle, picks the writeback value,
// drives the register-file write port and WB->decode forwarding, counts retirements, halts.
module simple_risc_writeback #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int RA_ADDR     = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [INSTR_WIDTH-1:0] in_pc,
    input  logic [INSTR_WIDTH-1:0] in_alu_result,
    input  logic [INSTR_WIDTH-1:0] in_ld_result,
    input  logic [ADDR_WIDTH-1:0]  in_rd_addr,
    input  logic                   in_is_wb,
    input  logic                   in_is_ld,
    input  logic                   in_is_call,
    input  logic                   in_is_halt,
    input  logic                   stall,
    input  logic [ADDR_WIDTH-1:0]  dec_rs1,
    input  logic [ADDR_WIDTH-1:0]  dec_rs2,
    output logic                   in_ready,
    output logic [INSTR_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0]  reg_wb_addr,
    output logic                   wb_is_wb,
    output logic                   wb_dd_rs1_conflict,
    output logic                   wb_dd_rs2_conflict,
    output logic [INSTR_WIDTH-1:0] wb_fw_result,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired_cnt
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [INSTR_WIDTH-1:0] result_q, result_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wb_q, wb_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   accept;

    assign in_ready = (state_q == S_RUN) && !stall;
    assign accept   = in_valid && in_ready;

    // Call outranks load so the return address always lands in RA.
    always_comb begin
        result_d = in_alu_result;
        addr_d   = in_rd_addr;
        wb_d     = (in_is_wb || in_is_call) && !in_is_halt;
        if (in_is_call) begin
            result_d = in_pc + INSTR_WIDTH'(4);
            addr_d   = ADDR_WIDTH'(RA_ADDR);
        end else if (in_is_ld) begin
            result_d = in_ld_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            result_q <= '0;
            addr_q   <= '0;
            wb_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            result_q <= result_d;
            addr_q   <= addr_d;
            wb_q     <= wb_d;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (in_is_halt) begin
                state_q <= S_HALTED;
            end
        end else begin
            // Held result/address with the enable dropped: no duplicate write while stalled.
            wb_q <= 1'b0;
        end
    end

    assign result             = result_q;
    assign reg_wb_addr        = addr_q;
    assign wb_is_wb           = wb_q;
    assign halted             = (state_q == S_HALTED);
    assign retired_cnt        = cnt_q;
    assign wb_fw_result       = result_q;
    assign wb_dd_rs1_conflict = wb_q && (addr_q == dec_rs1);
    assign wb_dd_rs2_conflict = wb_q && (addr_q == dec_rs2);

endmodule

// File: tb/tb_simple_risc_writeback.sv
// Scoreboard bench for simple_risc_writeback (counter narrowed to 4 bits to reach saturation).
module tb_simple_risc_writeback;

    localparam int CW = 4;

    typedef struct packed {
        logic        wb;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        halted;
        logic [CW-1:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_is_wb, in_is_ld, in_is_call, in_is_halt, stall;
    logic [31:0] in_pc, in_alu_result, in_ld_result;
    logic [3:0]  in_rd_addr, dec_rs1, dec_rs2;
    logic        in_ready, wb_is_wb, wb_dd_rs1_conflict, wb_dd_rs2_conflict, halted;
    logic [31:0] result, wb_fw_result;
    logic [3:0]  reg_wb_addr;
    logic [CW-1:0] retired_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    exp_t sb[$];

    logic          m_halted;
    logic          m_wb;
    logic [3:0]    m_addr;
    logic [31:0]   m_res;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    simple_risc_writeback #(
        .INSTR_WIDTH(32), .ADDR_WIDTH(4), .RA_ADDR(15), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
        .in_ld_result(in_ld_result), .in_rd_addr(in_rd_addr),
        .in_is_wb(in_is_wb), .in_is_ld(in_is_ld), .in_is_call(in_is_call),
        .in_is_halt(in_is_halt), .stall(stall),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .in_ready(in_ready), .result(result), .reg_wb_addr(reg_wb_addr),
        .wb_is_wb(wb_is_wb), .wb_dd_rs1_conflict(wb_dd_rs1_conflict),
        .wb_dd_rs2_conflict(wb_dd_rs2_conflict), .wb_fw_result(wb_fw_result),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0; m_wb = 1'b0; m_addr = '0; m_res = '0; m_cnt = '0;
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".result"}, result, 32'h0);
        chk({tag, ".addr"}, {28'h0, reg_wb_addr}, 32'h0);
        chk({tag, ".wb"}, {31'h0, wb_is_wb}, 32'h0);
        chk({tag, ".halted"}, {31'h0, halted}, 32'h0);
        chk({tag, ".cnt"}, 32'(retired_cnt), 32'h0);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_is_wb = 0; in_is_ld = 0; in_is_call = 0; in_is_halt = 0;
        stall = 0; in_pc = '0; in_alu_result = '0; in_ld_result = '0; in_rd_addr = '0;
    endtask

    task automatic bundle(input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                          input logic [31:0] pc, input logic wb, input logic is_ld,
                          input logic call, input logic hlt);
        in_valid = 1; in_rd_addr = rd; in_alu_result = alu; in_ld_result = ld; in_pc = pc;
        in_is_wb = wb; in_is_ld = is_ld; in_is_call = call; in_is_halt = hlt;
    endtask

    // Called just after a negedge with inputs driven; advances one cycle and checks.
    task automatic step();
        logic acc;
        exp_t e;
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, !m_halted && !stall});
        acc = in_valid && !m_halted && !stall;
        if (acc) begin
            m_wb = (in_is_wb || in_is_call) && !in_is_halt;
            if (in_is_call) begin
                m_res = in_pc + 32'd4; m_addr = 4'd15;
            end else begin
                m_res = in_is_ld ? in_ld_result : in_alu_result; m_addr = in_rd_addr;
            end
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (in_is_halt) m_halted = 1'b1;
        end else begin
            m_wb = 1'b0;
        end
        e.wb = m_wb; e.addr = m_addr; e.data = m_res; e.halted = m_halted; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("result", result, e.data);
        chk("reg_wb_addr", {28'h0, reg_wb_addr}, {28'h0, e.addr});
        chk("wb_is_wb", {31'h0, wb_is_wb}, {31'h0, e.wb});
        chk("halted", {31'h0, halted}, {31'h0, e.halted});
        chk("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
        chk("fw_result", wb_fw_result, e.data);
        chk("rs1_conflict", {31'h0, wb_dd_rs1_conflict}, {31'h0, e.wb && (e.addr == dec_rs1)});
        chk("rs2_conflict", {31'h0, wb_dd_rs2_conflict}, {31'h0, e.wb && (e.addr == dec_rs2)});
        $display("cycle t=%0t acc=%0b res=0x%0h addr=%0d wb=%0b cnt=%0d halted=%0b",
                 $time, acc, result, reg_wb_addr, wb_is_wb, retired_cnt, halted);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        check_zero("reset");
        rst = 1'b0;
    endtask

    initial begin
        dec_rs1 = 4'd1; dec_rs2 = 4'd2;
        do_reset();

        // ALU write then idle: enable pulses for exactly one cycle
        bundle(4'd3, 32'h1234, 32'h0, 32'h0, 1, 0, 0, 0); step();
        idle_inputs(); step();

        // Load, then call+load: call wins, RA gets pc+4
        bundle(4'd5, 32'h1111, 32'hBEEF, 32'h0, 1, 1, 0, 0); step();
        bundle(4'd5, 32'h2222, 32'hDEAD, 32'h100, 1, 1, 1, 0); step();
        // Call at top of address space wraps
        bundle(4'd1, 32'h0, 32'h0, 32'hFFFF_FFFE, 0, 0, 1, 0); step();

        // Forwarding, including r0
        dec_rs1 = 4'd7; dec_rs2 = 4'd2;
        bundle(4'd7, 32'hA5, 32'h0, 32'h0, 1, 0, 0, 0); step();
        dec_rs2 = 4'd0;
        bundle(4'd0, 32'h5A, 32'h0, 32'h0, 1, 0, 0, 0); step();
        // Non-writing bundle must not forward
        bundle(4'd7, 32'h77, 32'h0, 32'h0, 0, 0, 0, 0); step();

        // Stall for three cycles with valid held, then release
        bundle(4'd9, 32'h9999, 32'h0, 32'h0, 1, 0, 0, 0);
        stall = 1;
        repeat (3) step();
        stall = 0; step();
        idle_inputs(); step();

        // Saturation: 20 accepts on a 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bundle(4'(i), 32'(i * 3), 32'h0, 32'h0, 1, 0, 0, 0); step();
        end
        chk("sat_cnt", 32'(retired_cnt), 32'd15);

        // Halt with is_wb and call set: no write, later bundles ignored
        do_reset();
        bundle(4'd6, 32'h66, 32'h0, 32'h0, 1, 0, 0, 0); step();
        bundle(4'd4, 32'h44, 32'h0, 32'h200, 1, 0, 1, 1); step();
        for (int i = 0; i < 3; i++) begin
            bundle(4'd8, 32'h88 + 32'(i), 32'h0, 32'h0, 1, 0, 0, 0); step();
        end

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        chk("async_rst.ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bundle(4'd2, 32'h22, 32'h0, 32'h0, 1, 0, 0, 0); step();
        idle_inputs(); step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
